vsync_gen: RTL
==============

// Module: vsync_gen
// PURPOSE
//   Vertical timing generator for the 640x480@60 VGA path; sits directly downstream of Hsync.
//   Counts lines by detecting each falling edge of Hsync's VGA_HSYNC (= start of a new line),
//   and drives VGA_VSYNC, a vertical blank flag, and the VRAM row index vpixel.
//   Also combines horizontal and vertical blanking into rgb_en for the RGB output stage.
// PARAMETERS
//   VSYNC_LINES    2    lines with VGA_VSYNC low (sync pulse)
//   VBP_LINES      29   vertical back-porch lines
//   VDISP_LINES    480  visible lines
//   VFP_LINES      10   vertical front-porch lines (frame total = 521 lines)
//   LINES_PER_ROW  5    visible lines per VRAM row (480/5 = 96 rows)
//   ROW_WIDTH      7    width of vpixel
// PORTS
//   clk          in   1          system clock (50 MHz)
//   reset        in   1          asynchronous, active-low reset
//   hsync_in     in   1          VGA_HSYNC from Hsync
//   hdeactivate  in   1          horizontal blank from Hsync (1 = blank)
//   VGA_VSYNC    out  1          vertical sync to connector, active low
//   vdeactivate  out  1          vertical blank (1 = not in visible lines)
//   vpixel       out  ROW_WIDTH  VRAM row index, 0..95
//   rgb_en       out  1          1 only when hdeactivate==0 and vdeactivate==0
//   frame_start  out  1          one-cycle pulse when the frame's line counter wraps to 0
// BEHAVIOUR
//   Reset (reset==0, async): VGA_VSYNC=0, vdeactivate=1, vpixel=0, rgb_en=0, frame_start=0,
//     hsync_d=0, line counter=0, rowcnt=0, state=VSYNC. The line in progress at reset release is line 0.
//   Edge detect: hsync_d <= hsync_in each cycle; line_tick = hsync_d & ~hsync_in (combinational).
//     All state/output updates from a tick take effect on the clock edge where line_tick==1,
//     i.e. one cycle after hsync_in falls. Rising edges and a constant hsync_in cause no tick.
//   Line counter: 10 bits, increments on line_tick, wraps 520->0; frame_start=1 for that cycle only.
//   FSM, states by line number after the tick:
//     VSYNC     lines 0..1      : VGA_VSYNC=0, vdeactivate=1
//     VBACK     lines 2..30     : VGA_VSYNC=1, vdeactivate=1
//     VDISPLAY  lines 31..510   : VGA_VSYNC=1, vdeactivate=0
//     VFRONT    lines 511..520  : VGA_VSYNC=1, vdeactivate=1; line 520 tick -> VSYNC, line 0
//     Boundaries derived from parameters; transitions occur only on line_tick.
//   Row index: entering VDISPLAY sets vpixel=0, rowcnt=0. Each tick inside VDISPLAY: if
//     rowcnt==LINES_PER_ROW-1 then rowcnt=0, vpixel=vpixel+1, else rowcnt+1. vpixel is
//     forced to 0 on leaving VDISPLAY; it never exceeds 95 (line 510 is row 95's last line).
//   rgb_en: registered, rgb_en <= ~hdeactivate & ~vdeactivate_next; one-cycle latency vs hdeactivate.
//   Mid-operation reset: all outputs return to reset values immediately (async); after release,
//     timing restarts at line 0 independent of where Hsync is.
//   hsync_in glitch-free assumption not required: any 1->0 sampled edge counts as a line.
// TESTING
//   1 Reset low mid-frame -> all outputs at reset values within same cycle; release -> VGA_VSYNC=0.
//   2 Drive hsync_in with 1600-cycle line (192 low, 1408 high) -> VGA_VSYNC low for exactly
//     2 lines (3200 cycles), period 521 lines = 833600 cycles; frame_start once per frame.
//   3 Count ticks: vdeactivate falls on tick 31, rises on tick 511; 480 lines visible.
//   4 vpixel: 0 for ticks 31..35, 1 for 36..40, 95 for 506..510, 0 from tick 511.
//   5 hdeactivate toggled during line 40 -> rgb_en follows one cycle later; during line 5 rgb_en=0.
//   6 hsync_in held high 5000 cycles then low -> exactly one tick; no change while held.

Source files
------------

// File: rtl/vsync_gen.sv
// vsync_gen: vertical VGA timing (line counting from Hsync falling edges), VRAM row index and RGB enable.
module vsync_gen #(
  parameter int VSYNC_LINES   = 2,
  parameter int VBP_LINES     = 29,
  parameter int VDISP_LINES   = 480,
  parameter int VFP_LINES     = 10,
  parameter int LINES_PER_ROW = 5,
  parameter int ROW_WIDTH     = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hsync_in,
  input  logic                 hdeactivate,
  output logic                 VGA_VSYNC,
  output logic                 vdeactivate,
  output logic [ROW_WIDTH-1:0] vpixel,
  output logic                 rgb_en,
  output logic                 frame_start
);
  localparam int LINE_W = 10;
  localparam int RC_W   = (LINES_PER_ROW > 1) ? $clog2(LINES_PER_ROW) : 1;
  localparam logic [LINE_W-1:0] VBACK_START  = LINE_W'(VSYNC_LINES);
  localparam logic [LINE_W-1:0] VDISP_START  = LINE_W'(VSYNC_LINES + VBP_LINES);
  localparam logic [LINE_W-1:0] VFRONT_START = LINE_W'(VSYNC_LINES + VBP_LINES + VDISP_LINES);
  localparam logic [LINE_W-1:0] LAST_LINE    = LINE_W'(VSYNC_LINES + VBP_LINES + VDISP_LINES + VFP_LINES - 1);
  localparam logic [RC_W-1:0]   ROW_LAST     = RC_W'(LINES_PER_ROW - 1);

  typedef enum logic [1:0] {VSYNC, VBACK, VDISPLAY, VFRONT} state_t;

  state_t                state_q, state_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [RC_W-1:0]       rowcnt_q, rowcnt_d;
  logic [ROW_WIDTH-1:0]  vpixel_q, vpixel_d;
  logic                  hsync_d_q;
  logic                  vsync_q, vsync_d;
  logic                  vdeact_q, vdeact_d;
  logic                  rgb_en_q, rgb_en_d;
  logic                  frame_start_q, frame_start_d;
  logic                  line_tick;

  // A line begins at every sampled 1->0 of Hsync; state advances only on that tick.
  always_comb begin
    line_tick     = hsync_d_q & ~hsync_in;
    line_d        = line_q;
    state_d       = state_q;
    rowcnt_d      = rowcnt_q;
    vpixel_d      = vpixel_q;
    frame_start_d = 1'b0;
    if (line_tick) begin
      line_d        = (line_q == LAST_LINE) ? '0 : line_q + 1'b1;
      frame_start_d = (line_q == LAST_LINE);
      case (state_q)
        VSYNC:    state_d = (line_d == VBACK_START) ? VBACK : VSYNC;
        VBACK: begin
          if (line_d == VDISP_START) begin
            state_d  = VDISPLAY;
            vpixel_d = '0;
            rowcnt_d = '0;
          end
        end
        VDISPLAY: begin
          if (line_d == VFRONT_START) begin
            state_d  = VFRONT;
            vpixel_d = '0;
            rowcnt_d = '0;
          end else begin
            rowcnt_d = (rowcnt_q == ROW_LAST) ? '0 : rowcnt_q + 1'b1;
            vpixel_d = (rowcnt_q == ROW_LAST) ? vpixel_q + 1'b1 : vpixel_q;
          end
        end
        default:  state_d = (line_d == '0) ? VSYNC : VFRONT;
      endcase
    end
    vsync_d  = (state_d != VSYNC);
    vdeact_d = (state_d != VDISPLAY);
    rgb_en_d = ~hdeactivate & ~vdeact_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= VSYNC;
      line_q        <= '0;
      rowcnt_q      <= '0;
      vpixel_q      <= '0;
      hsync_d_q     <= 1'b0;
      vsync_q       <= 1'b0;
      vdeact_q      <= 1'b1;
      rgb_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      rowcnt_q      <= rowcnt_d;
      vpixel_q      <= vpixel_d;
      hsync_d_q     <= hsync_in;
      vsync_q       <= vsync_d;
      vdeact_q      <= vdeact_d;
      rgb_en_q      <= rgb_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign VGA_VSYNC   = vsync_q;
  assign vdeactivate = vdeact_q;
  assign vpixel      = vpixel_q;
  assign rgb_en      = rgb_en_q;
  assign frame_start = frame_start_q;
endmodule
